// File: rtl/strhw_block_loader_if.sv
// Message-beat input stream and assembled-block output of the Streebog block loader.
interface strhw_block_loader_if;
  logic [63:0]  s_data_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic         s_last_i;
  logic [3:0]   s_bytes_i;
  logic [511:0] block_o;
  logic [5:0]   block_size_o;
  logic         block_last_o;
  logic         block_valid_o;
  logic         block_ready_i;

  modport master (
    output s_data_i, s_valid_i, s_last_i, s_bytes_i, block_ready_i,
    input  s_ready_o, block_o, block_size_o, block_last_o, block_valid_o
  );

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, s_bytes_i, block_ready_i,
    output s_ready_o, block_o, block_size_o, block_last_o, block_valid_o
  );
endinterface

// File: rtl/strhw_block_loader.sv
// Packs 64-bit message beats into 512-bit Streebog blocks with 0x01/zero padding,
// tagging each block with its byte count and a final-block flag.
module strhw_block_loader (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  strhw_block_loader_if.slave       bus
);

  typedef enum logic [1:0] {FILL, OUT, PAD} state_e;

  state_e           state_q, state_d;
  logic [2:0]       w_q, w_d;
  logic             pad_q, pad_d;
  logic [63:0][7:0] buf_q, buf_d;
  logic [5:0]       size_q, size_d;
  logic             last_q, last_d;

  logic [3:0]       nb;
  logic [6:0]       s;
  logic [63:0][7:0] beat_buf;

  // Non-last beats always carry 8 bytes; oversize counts saturate at 8.
  always_comb begin
    nb = 4'd8;
    if (bus.s_last_i && bus.s_bytes_i < 4'd8) nb = bus.s_bytes_i;
  end

  assign s = {1'b0, w_q, 3'b000} + {3'b000, nb};

  // Buffer image after storing the current beat. Words above w are already
  // zero, so padding only touches word w (or the first byte of word w+1).
  always_comb begin
    beat_buf = buf_q;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < nb)
        beat_buf[{w_q, 3'(j)}] = bus.s_data_i[8*j +: 8];
      else if (bus.s_last_i && 4'(j) == nb)
        beat_buf[{w_q, 3'(j)}] = 8'h01;
      else
        beat_buf[{w_q, 3'(j)}] = 8'h00;
    end
    if (bus.s_last_i && nb == 4'd8 && w_q != 3'd7)
      beat_buf[{w_q + 3'd1, 3'b000}] = 8'h01;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pad_d   = pad_q;
    buf_d   = buf_q;
    size_d  = size_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: if (bus.s_valid_i) begin
        buf_d = beat_buf;
        if (bus.s_last_i) begin
          state_d = OUT;
          if (!s[6]) begin
            size_d = s[5:0];
            last_d = 1'b1;
          end else begin
            size_d = 6'd0;
            last_d = 1'b0;
            pad_d  = 1'b1;
          end
        end else if (w_q == 3'd7) begin
          state_d = OUT;
          size_d  = 6'd0;
          last_d  = 1'b0;
        end else begin
          w_d = w_q + 3'd1;
        end
      end
      OUT: if (bus.block_ready_i) begin
        buf_d = '0;
        if (pad_q) begin
          // Message filled whole blocks exactly: emit a padding-only block.
          buf_d[0] = 8'h01;
          size_d   = 6'd0;
          last_d   = 1'b1;
          state_d  = PAD;
        end else begin
          w_d     = 3'd0;
          state_d = FILL;
        end
      end
      PAD: if (bus.block_ready_i) begin
        pad_d   = 1'b0;
        w_d     = 3'd0;
        buf_d   = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    if (clr_i) begin
      state_d = FILL;
      w_d     = 3'd0;
      pad_d   = 1'b0;
      buf_d   = '0;
      size_d  = 6'd0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      w_q     <= 3'd0;
      pad_q   <= 1'b0;
      buf_q   <= '0;
      size_q  <= 6'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      pad_q   <= pad_d;
      buf_q   <= buf_d;
      size_q  <= size_d;
      last_q  <= last_d;
    end
  end

  assign bus.s_ready_o     = (state_q == FILL);
  assign bus.block_valid_o = (state_q != FILL);
  assign bus.block_o       = buf_q;
  assign bus.block_size_o  = size_q;
  assign bus.block_last_o  = last_q;

endmodule

// File: tb/tb_strhw_block_loader.sv
// Directed bench for strhw_block_loader: single-beat padding table plus
// hand-written multi-block, backpressure, flush and reset sequences.
module tb_strhw_block_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   passed = 0;
  int   total = 0;

  strhw_block_loader_if bus ();

  strhw_block_loader dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         pre;
    logic [63:0]  data;
    logic [3:0]   nb;
    logic [511:0] exp_blk;
    logic [5:0]   exp_size;
  } vec_t;

  localparam logic [63:0] PRE = 64'h0807060504030201;
  localparam logic [63:0] G   = 64'hFFEEDDCCBBAA9988;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n = 0;
    bus.s_data_i  = d;
    bus.s_last_i  = last;
    bus.s_bytes_i = nb;
    bus.s_valid_i = 1'b1;
    while (!bus.s_ready_o && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", 512'(bus.s_ready_o), 512'd1);
    tick();
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.s_bytes_i = '0;
  endtask

  // Called #1 after the edge that accepted the completing beat.
  task automatic take_block(input string nm, input logic [511:0] eb,
                            input logic [5:0] es, input logic el);
    check({nm, "_valid"}, 512'(bus.block_valid_o), 512'd1);
    check({nm, "_sready"}, 512'(bus.s_ready_o), 512'd0);
    check({nm, "_block"}, bus.block_o, eb);
    check({nm, "_size"}, 512'(bus.block_size_o), 512'(es));
    check({nm, "_last"}, 512'(bus.block_last_o), 512'(el));
    bus.block_ready_i = 1'b1;
    tick();
    bus.block_ready_i = 1'b0;
  endtask

  task automatic expect_fill(input string nm);
    check({nm, "_valid0"}, 512'(bus.block_valid_o), 512'd0);
    check({nm, "_sready1"}, 512'(bus.s_ready_o), 512'd1);
  endtask

  function automatic logic [63:0] beat_of(input int i);
    return {8{8'(8'h10 + i)}};
  endfunction

  vec_t tbl[7];
  logic [511:0] full;
  logic [511:0] hold_blk;

  initial begin
    bus.s_data_i      = '0;
    bus.s_valid_i     = 1'b0;
    bus.s_last_i      = 1'b0;
    bus.s_bytes_i     = '0;
    bus.block_ready_i = 1'b0;

    tbl[0] = '{1'b0, G, 4'd0, 512'h1, 6'd0};
    tbl[1] = '{1'b0, 64'h5A5A5A5A5A636261, 4'd3, 512'h01636261, 6'd3};
    tbl[2] = '{1'b0, G, 4'd7, 512'h01EEDDCCBBAA9988, 6'd7};
    tbl[3] = '{1'b0, G, 4'd8, 512'h01FFEEDDCCBBAA9988, 6'd8};
    tbl[4] = '{1'b0, G, 4'd15, 512'h01FFEEDDCCBBAA9988, 6'd8};
    tbl[5] = '{1'b1, 64'hFFFFFFFFFFFF0B0A, 4'd2, 512'h010B0A0807060504030201, 6'd10};
    tbl[6] = '{1'b1, G, 4'd0, 512'h010807060504030201, 6'd8};

    // Reset values
    #2;
    check("rst_block", bus.block_o, 512'd0);
    check("rst_size", 512'(bus.block_size_o), 512'd0);
    check("rst_last", 512'(bus.block_last_o), 512'd0);
    check("rst_valid", 512'(bus.block_valid_o), 512'd0);
    check("rst_sready", 512'(bus.s_ready_o), 512'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pre) send(PRE, 1'b0, 4'd0);
      send(tbl[i].data, 1'b1, tbl[i].nb);
      take_block($sformatf("vec%0d", i), tbl[i].exp_blk, tbl[i].exp_size, 1'b1);
      expect_fill($sformatf("vec%0d_after", i));
    end

    // 64-byte message: full block, then PAD block the very next cycle
    full = '0;
    for (int i = 0; i < 8; i++) begin
      full[64*i +: 64] = beat_of(i);
      send(beat_of(i), i == 7, 4'd8);
    end
    check("m64_valid", 512'(bus.block_valid_o), 512'd1);
    check("m64_block", bus.block_o, full);
    check("m64_size", 512'(bus.block_size_o), 512'd0);
    check("m64_last", 512'(bus.block_last_o), 512'd0);
    bus.block_ready_i = 1'b1;
    tick();
    check("m64_pad_valid", 512'(bus.block_valid_o), 512'd1);
    check("m64_pad_sready", 512'(bus.s_ready_o), 512'd0);
    check("m64_pad_block", bus.block_o, 512'h1);
    check("m64_pad_size", 512'(bus.block_size_o), 512'd0);
    check("m64_pad_last", 512'(bus.block_last_o), 512'd1);
    tick();
    bus.block_ready_i = 1'b0;
    expect_fill("m64_after");

    // 70-byte message: full block (not last), then 6-byte padded block
    for (int i = 0; i < 8; i++) send(beat_of(i), 1'b0, 4'd0);
    take_block("m70_a", full, 6'd0, 1'b0);
    expect_fill("m70_mid");
    send(64'hDEADBEEFCAFE1234, 1'b1, 4'd6);
    take_block("m70_b", 512'h0001BEEFCAFE1234, 6'd6, 1'b1);

    // Backpressure: outputs hold, offered beats are refused
    send(64'h0000000000000055, 1'b1, 4'd1);
    hold_blk = bus.block_o;
    check("bp_block0", hold_blk, 512'h0155);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 64'h9999999999999999;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_block", bus.block_o, 512'h0155);
      check("bp_size", 512'(bus.block_size_o), 512'd1);
      check("bp_last", 512'(bus.block_last_o), 512'd1);
      check("bp_valid", 512'(bus.block_valid_o), 512'd1);
      check("bp_sready", 512'(bus.s_ready_o), 512'd0);
    end
    bus.s_valid_i = 1'b0;
    bus.block_ready_i = 1'b1;
    tick();
    bus.block_ready_i = 1'b0;
    expect_fill("bp_release");
    send(64'hEEEEEEEEEEEEEEAA, 1'b1, 4'd1);
    take_block("bp_next", 512'h01AA, 6'd1, 1'b1);

    // Flush after 3 beats, with a beat offered in the flush cycle
    for (int i = 0; i < 3; i++) send(beat_of(i), 1'b0, 4'd0);
    clr = 1'b1;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 64'h7777777777777777;
    tick();
    clr = 1'b0;
    bus.s_valid_i = 1'b0;
    expect_fill("clr3");
    check("clr3_block", bus.block_o, 512'd0);
    send(64'h00000000000000AA, 1'b1, 4'd1);
    take_block("clr3_next", 512'h01AA, 6'd1, 1'b1);

    // Flush while a block is pending
    send(G, 1'b1, 4'd4);
    check("clrout_valid", 512'(bus.block_valid_o), 512'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_fill("clrout");
    send(64'h00000000000000AA, 1'b1, 4'd1);
    take_block("clrout_next", 512'h01AA, 6'd1, 1'b1);

    // Asynchronous reset mid-block
    for (int i = 0; i < 2; i++) send(beat_of(i), 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_block", bus.block_o, 512'd0);
    check("arst_valid", 512'(bus.block_valid_o), 512'd0);
    check("arst_size", 512'(bus.block_size_o), 512'd0);
    check("arst_last", 512'(bus.block_last_o), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(64'h00000000000000AA, 1'b1, 4'd1);
    take_block("arst_next", 512'h01AA, 6'd1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/strhw_block_loader.md
# strhw_block_loader

Upstream feeder for the Streebog compression stage. Accepts the message as a stream of 64-bit beats with valid/ready, assembles 512-bit blocks and applies Streebog padding (message bytes, then 0x01, then zeros). Each block is presented with its valid-byte count and a final-block flag, so the control logic can drive the stage's block and block_size inputs and the matching trigger.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous flush: discards the partial block and any pending output; returns to FILL.
- s_data_i  in  64  message beat; byte lane j is s_data_i[8j+7:8j] and is the j-th byte in arrival order.
- s_valid_i  in  1  beat valid.
- s_ready_o  out  1  beat accepted when s_valid_i and s_ready_o are both high at a clock edge.
- s_last_i  in  1  beat is the last of the message.
- s_bytes_i  in  4  valid bytes in a last beat, 0..8; values >8 are treated as 8; ignored when s_last_i=0 (non-last beats carry 8 bytes).
- block_o  out  512  assembled block; block byte k is block_o[8k+7:8k].
- block_size_o  out  6  message bytes in block mod 64; a full block reports 0.
- block_last_o  out  1  final (padded) block of the message.
- block_valid_o  out  1  block_o, block_size_o and block_last_o are valid.
- block_ready_i  in  1  consumer accepts the block.

## Operation
- FSM states: FILL, OUT, PAD. Reset state is FILL.
- Word index w is 3 bits (0..7). Each accepted beat is written to block bytes 8w..8w+7.
- FILL:
  - s_ready_o=1.
  - Non-last beat with w<7: store it, w+1.
  - Non-last beat with w=7: store it, register block_size_o=0 and block_last_o=0, go to OUT.
  - Last beat carrying b bytes: s = 8w+b.
    - If s<64: bytes s+1..63 are zeroed, byte s = 0x01, and unused lanes of the beat are masked to zero (input garbage never reaches block_o). Register block_size_o=s and block_last_o=1, go to OUT.
    - If s=64 (w=7, b=8): full block, block_last_o=0, set pad_pending, go to OUT.
- OUT:
  - s_ready_o=0, block_valid_o=1. Outputs hold stable until block_ready_i=1.
  - On handshake: if pad_pending, go to PAD. Otherwise clear w and the block buffer and go to FILL.
- PAD:
  - Presents block_o = 512'h1 (byte 0 = 0x01), block_size_o=0, block_last_o=1, block_valid_o=1.
  - On handshake: clear pad_pending, w and the block buffer, go to FILL.
- Empty message (last beat with b=0 at w=0): single block 512'h1, size 0, last=1.
- Last beat with b=0 at w>0: s=8w; byte 8w = 0x01.
- clr_i overrides every other event in the same cycle: state FILL, w=0, pad_pending=0, buffer zeroed, block_valid_o=0. A beat offered in that cycle is not stored, although s_ready_o may read 1.

## Timing
- Reset (rst_ni low, asynchronous): block_o=0, block_size_o=0, block_last_o=0, block_valid_o=0, state FILL, w=0, pad_pending=0. s_ready_o follows the state and reads 1, but no beat is accepted while rst_ni is low.
- s_ready_o is decoded from the state register only; it has no combinational path from s_valid_i or block_ready_i.
- Latency: block_valid_o rises in the cycle after the edge that accepts the completing beat.
- After an OUT or PAD handshake edge, the next cycle is FILL with s_ready_o=1.
- Throughput with block_ready_i tied high: 9 cycles per full block. A message that is an exact multiple of 64 bytes costs one extra cycle for the PAD block.
- Backpressure: while block_valid_o is high and block_ready_i is low, block_o, block_size_o, block_last_o and block_valid_o hold unchanged for any number of cycles.
- Reset asserted mid-block or mid-handshake: immediate return to reset values, partial data lost.

## Test plan
- Empty message: one beat, s_last_i=1, s_bytes_i=0 -> one block: block_o=512'h1, size 0, last=1, block_valid_o one cycle after acceptance.
- 3-byte message 0x636261 -> block_o = 512'h01636261, size 3, last=1; garbage in lanes 3..7 does not appear.
- 64-byte message of 8 beats, block_ready_i high -> full block (size 0, last=0), then PAD block 512'h1 (last=1) in the next cycle; s_ready_o stays 0 across both.
- 70-byte message (8 beats, then last beat with b=6) -> full block (last=0), then block with bytes 0..5 = data, byte 6 = 0x01, size 6, last=1.
- Backpressure: hold block_ready_i low 5 cycles with a block pending -> outputs constant, s_ready_o=0, no beat accepted; release -> one handshake, FILL next cycle.
- clr_i after 3 beats, and separately during OUT -> block_valid_o=0 and s_ready_o=1 next cycle. A following 1-byte message 0xAA yields 512'h01AA, size 1, last=1, with no residue from the flushed data. rst_ni pulsed mid-block -> all outputs 0 immediately.
